// File: rtl/sterm_pkg.sv
// Shared definitions for the STERM predictor: command codes, guard states,
// chip-select decode and address-field extraction.
package sterm_pkg;

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_ACT    = 3'd1;
  localparam logic [2:0] CMD_RD     = 3'd2;
  localparam logic [2:0] CMD_WR     = 3'd3;
  localparam logic [2:0] CMD_PRE    = 3'd4;
  localparam logic [2:0] CMD_PREALL = 3'd5;
  localparam logic [2:0] CMD_REF    = 3'd6;

  typedef enum logic {
    GUARD_IDLE = 1'b0,
    GUARD_DONE = 1'b1
  } guard_state_e;

  // a holds A[31:2]; RAM is the bottom 1 GiB, ROM the 0x4xxx_xxxx window.
  function automatic logic cs_decode(input logic [2:0] fc, input logic [29:0] a);
    return fc[2] & ~fc[0] & ((a[29:28] == 2'b00) | (a[29:26] == 4'h4));
  endfunction

  function automatic logic [31:0] field_get(input logic [29:0] a, input int lsb, input int w);
    logic [31:0] full_addr;
    full_addr = {a, 2'b00};
    return (full_addr >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] col_of(input logic [29:0] a, input int col_lsb, input int col_w);
    return field_get(a, col_lsb, col_w);
  endfunction

  function automatic logic [31:0] row_of(input logic [29:0] a, input int col_lsb, input int col_w,
                                         input int row_w);
    return field_get(a, col_lsb + col_w, row_w);
  endfunction

  function automatic logic [31:0] bank_of(input logic [29:0] a, input int col_lsb, input int col_w,
                                          input int row_w, input int bank_w);
    return field_get(a, col_lsb + col_w + row_w, bank_w);
  endfunction

endpackage

// File: rtl/sterm_predictor_if.sv
// 68030-side bus bundle of the STERM predictor, plus controller command and status.
interface sterm_predictor_if #(
  parameter int NBANK = 4,
  parameter int CNT_W = 16
);
  logic [2:0]       FC;
  logic [29:0]      A;
  logic             nAS;
  logic [2:0]       CMD;
  logic             STERM;
  logic             nSTERM;
  logic [NBANK-1:0] OPEN;
  logic [CNT_W-1:0] HITCNT;

  modport master (
    output FC, A, nAS, CMD, STERM,
    input  nSTERM, OPEN, HITCNT
  );

  modport slave (
    input  FC, A, nAS, CMD, STERM,
    output nSTERM, OPEN, HITCNT
  );
endinterface

// File: rtl/sterm_bank_entry.sv
// One tracked DRAM bank: open row, predicted next column, and the match
// against the current access.
module sterm_bank_entry
  import sterm_pkg::*;
#(
  parameter int COL_W = 9,
  parameter int ROW_W = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sel_i,
  input  logic [2:0]       cmd_i,
  input  logic [ROW_W-1:0] ar_i,
  input  logic [COL_W-1:0] ac_i,
  output logic             open_o,
  output logic             match_o
);

  logic             v_q, v_d;
  logic             ncv_q, ncv_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] nc_q, nc_d;
  logic             row_hit_s;

  assign row_hit_s = v_q & (row_q == ar_i);

  always_comb begin
    v_d   = v_q;
    ncv_d = ncv_q;
    row_d = row_q;
    nc_d  = nc_q;
    case (cmd_i)
      CMD_ACT: begin
        if (sel_i) begin
          v_d   = 1'b1;
          row_d = ar_i;
          nc_d  = ac_i + COL_W'(1'b1);
          ncv_d = ~&ac_i;
        end else begin
          v_d = v_q;
        end
      end
      CMD_RD, CMD_WR: begin
        // The last column never predicts; the next ACT or RD/WR re-arms.
        if (sel_i && row_hit_s) begin
          nc_d  = ac_i + COL_W'(1'b1);
          ncv_d = ~&ac_i;
        end else begin
          nc_d = nc_q;
        end
      end
      CMD_PRE: begin
        if (sel_i) begin
          v_d   = 1'b0;
          ncv_d = 1'b0;
        end else begin
          v_d = v_q;
        end
      end
      CMD_PREALL, CMD_REF: begin
        v_d   = 1'b0;
        ncv_d = 1'b0;
      end
      default: begin
        v_d = v_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= 1'b0;
      ncv_q <= 1'b0;
      row_q <= '0;
      nc_q  <= '0;
    end else begin
      v_q   <= v_d;
      ncv_q <= ncv_d;
      row_q <= row_d;
      nc_q  <= nc_d;
    end
  end

  assign open_o  = v_q;
  assign match_o = row_hit_s & ncv_q & (nc_q == ac_i);

endmodule

// File: rtl/sterm_predictor.sv
// Multi-bank early-termination predictor for 68030 RAM/ROM accesses, with a
// one-shot-per-bus-cycle guard and optional registered nSTERM.
module sterm_predictor
  import sterm_pkg::*;
#(
  parameter int NBANK   = 4,
  parameter int COL_W   = 9,
  parameter int ROW_W   = 13,
  parameter int COL_LSB = 2,
  parameter int PIPE    = 0,
  parameter int CNT_W   = 16
) (
  input logic              CLK,
  input logic              RST,
  sterm_predictor_if.slave bus
);

  localparam int BANK_W = $clog2(NBANK);

  logic [COL_W-1:0]  ac_s;
  logic [ROW_W-1:0]  ar_s;
  logic [BANK_W-1:0] bank_s;
  logic [NBANK-1:0]  open_s;
  logic [NBANK-1:0]  match_s;
  logic              cs_s;
  logic              hit_s;
  logic              pred_s;
  logic              pred_out_s;
  logic              term_s;
  guard_state_e      state_q;
  logic [CNT_W-1:0]  hitcnt_q;

  assign ac_s   = COL_W'(col_of(bus.A, COL_LSB, COL_W));
  assign ar_s   = ROW_W'(row_of(bus.A, COL_LSB, COL_W, ROW_W));
  assign bank_s = BANK_W'(bank_of(bus.A, COL_LSB, COL_W, ROW_W, BANK_W));

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    sterm_bank_entry #(
      .COL_W (COL_W),
      .ROW_W (ROW_W)
    ) u_entry (
      .clk_i   (CLK),
      .rst_i   (RST),
      .sel_i   (bank_s == BANK_W'(g)),
      .cmd_i   (bus.CMD),
      .ar_i    (ar_s),
      .ac_i    (ac_s),
      .open_o  (open_s[g]),
      .match_o (match_s[g])
    );
  end

  assign cs_s   = cs_decode(bus.FC, bus.A);
  assign hit_s  = cs_s & ~bus.nAS & match_s[bank_s];
  assign pred_s = hit_s & (state_q == GUARD_IDLE);

  if (PIPE != 0) begin : g_pipe
    logic pred_q;

    // Delays the prediction by one clock; reset drops a pending term.
    always_ff @(posedge CLK) begin
      if (RST) begin
        pred_q <= 1'b0;
      end else begin
        pred_q <= pred_s;
      end
    end

    assign pred_out_s = pred_q;
  end else begin : g_comb
    assign pred_out_s = pred_s;
  end

  assign term_s = (PIPE != 0) ? pred_out_s : hit_s;

  // Guard: at most one predicted term per bus cycle; each issue is counted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= GUARD_IDLE;
      hitcnt_q <= '0;
    end else begin
      case (state_q)
        GUARD_IDLE: begin
          if (term_s && !bus.nAS) begin
            state_q <= GUARD_DONE;
            if (!(&hitcnt_q)) begin
              hitcnt_q <= hitcnt_q + CNT_W'(1'b1);
            end
          end
        end
        GUARD_DONE: begin
          if (bus.nAS) begin
            state_q <= GUARD_IDLE;
          end
        end
        default: begin
          state_q <= GUARD_IDLE;
        end
      endcase
    end
  end

  assign bus.nSTERM = ~(bus.STERM | pred_out_s);
  assign bus.OPEN   = open_s;
  assign bus.HITCNT = hitcnt_q;

endmodule
